// File: rtl/coeff_token_pkg.sv
// coeff_token_pkg: shared widths and packer state encoding for the coeff_token encoder.
package coeff_token_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int CODE_W = 16;
  localparam int LEN_W = 5;
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/coeff_token_enc_lut.sv
// coeff_token_enc_lut: Table 9-5 coeff_token codeword lookup for 0<=nC<2 (nC=-1 added by COEFF_TOKEN_CHROMA_DC_EN).
module coeff_token_enc_lut
  import coeff_token_pkg::*;
(
  input  logic [4:0]        tc_i,
  input  logic [1:0]        t1_i,
  input  logic              chroma_dc_i,
  output logic [CODE_W-1:0] code_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              illegal_o
);
  // indexed by {TotalCoeff, TrailingOnes}; every codeword value fits in 4 bits
  localparam logic [LEN_W-1:0] LEN_T [68] = '{
    1, 0, 0, 0,    6, 2, 0, 0,    8, 6, 3, 0,    9, 8, 7, 5,
    10, 9, 8, 6,   11, 10, 9, 7,  13, 11, 10, 8, 13, 13, 11, 9,
    13, 13, 13, 10, 14, 14, 13, 11, 14, 14, 14, 13, 15, 15, 14, 14,
    15, 15, 15, 14, 16, 15, 15, 15, 16, 16, 16, 15, 16, 16, 16, 16,
    16, 16, 16, 16};
  localparam logic [3:0] VAL_T [68] = '{
    1, 0, 0, 0,    5, 1, 0, 0,    7, 4, 1, 0,    7, 6, 5, 3,
    7, 6, 5, 3,    7, 6, 5, 4,    15, 6, 5, 4,   11, 14, 5, 4,
    8, 10, 13, 4,  15, 14, 9, 4,  11, 10, 13, 12, 15, 14, 9, 12,
    11, 10, 13, 8, 15, 1, 9, 12,  11, 14, 13, 8, 7, 10, 9, 12,
    4, 6, 5, 8};
  logic       bad;
  logic [6:0] idx;
  assign bad = tc_i > 5'd16 || {3'b0, t1_i} > tc_i;
  assign idx = bad ? 7'd0 : {tc_i, t1_i};
`ifdef COEFF_TOKEN_CHROMA_DC_EN
  localparam logic [LEN_W-1:0] CLEN_T [20] = '{
    2, 0, 0, 0, 6, 1, 0, 0, 6, 6, 3, 0, 6, 7, 7, 6, 6, 8, 8, 7};
  localparam logic [3:0] CVAL_T [20] = '{
    1, 0, 0, 0, 7, 1, 0, 0, 4, 6, 1, 0, 3, 3, 2, 5, 2, 3, 2, 0};
  logic       bad_c;
  logic [4:0] cidx;
  assign bad_c = tc_i > 5'd4 || {3'b0, t1_i} > tc_i;
  assign cidx = bad_c ? 5'd0 : {tc_i[2:0], t1_i};
  assign illegal_o = chroma_dc_i ? bad_c : bad;
  assign len_o = chroma_dc_i ? CLEN_T[cidx] : LEN_T[idx];
  assign code_o = CODE_W'(chroma_dc_i ? CVAL_T[cidx] : VAL_T[idx]);
`else
  logic unused_chroma;
  assign unused_chroma = chroma_dc_i;
  assign illegal_o = bad;
  assign len_o = LEN_T[idx];
  assign code_o = CODE_W'(VAL_T[idx]);
`endif
endmodule

// File: rtl/coeff_token_enc_packer.sv
// coeff_token_enc_packer: coeff_token encoder feeding an MSB-first bit accumulator that emits bytes with flush/align.
// COEFF_TOKEN_CHROMA_DC_EN enables the ChromaDC (nC=-1) table.
module coeff_token_enc_packer
  import coeff_token_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       InValid,
  output logic       InReady,
  input  logic [4:0] TotalCoeff,
  input  logic [1:0] TrailingOnes,
  input  logic       ChromaDC,
  input  logic       FlushReq,
  output logic       FlushDone,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [7:0] OutByte,
  output logic       Err
);
  localparam int FW = $clog2(ACC_W + 1);
  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              in_ready_q, out_valid_q, done_q, err_q;
  logic [7:0]        out_byte_q;
  logic [CODE_W-1:0] code;
  logic [LEN_W-1:0]  len;
  logic              illegal, accept, pop, push;
  coeff_token_enc_lut u_lut (
    .tc_i(TotalCoeff),
    .t1_i(TrailingOnes),
    .chroma_dc_i(ChromaDC),
    .code_o(code),
    .len_o(len),
    .illegal_o(illegal)
  );
  assign accept = InValid && in_ready_q;
  assign pop = out_valid_q && OutReady;
  assign push = accept && !illegal;
  // new bits land directly below the post-pop fill level; pad bits are already zero
  always_comb begin
    acc_d = pop ? acc_q << 8 : acc_q;
    fill_d = pop ? fill_q - FW'(8) : fill_q;
    if (push) begin
      acc_d = acc_d | (ACC_W'(code) << (FW'(ACC_W) - fill_d - FW'(len)));
      fill_d = fill_d + FW'(len);
    end
    if (state_q == FLUSH && fill_d[2:0] != 3'd0) fill_d = (fill_d | FW'(7)) + FW'(1);
    state_d = state_q == RUN ? (FlushReq && !accept ? FLUSH : RUN)
            : state_q == FLUSH ? (fill_q == '0 ? DONE : FLUSH) : RUN;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RUN;
      acc_q <= '0;
      fill_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      fill_q <= fill_d;
      in_ready_q <= state_d == RUN && fill_d <= FW'(ACC_W - 16);
      out_valid_q <= fill_d >= FW'(8);
      out_byte_q <= acc_d[ACC_W-1 -: 8];
      done_q <= state_d == DONE;
      err_q <= accept && illegal;
    end
  end
  assign InReady = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutByte = out_byte_q;
  assign FlushDone = done_q;
  assign Err = err_q;
endmodule

// File: tb/tb_coeff_token_enc_packer.sv
// tb_coeff_token_enc_packer: scoreboard bench; a bit-string model of Table 9-5 predicts every packed byte.
module tb_coeff_token_enc_packer;
  logic       Clk = 1'b0, Rst = 1'b1, InValid = 1'b0, ChromaDC = 1'b0, FlushReq = 1'b0, OutReady = 1'b0;
  logic [4:0] TotalCoeff = '0;
  logic [1:0] TrailingOnes = '0;
  logic       InReady, FlushDone, OutValid, Err;
  logic [7:0] OutByte;
  int         n_chk = 0, n_fail = 0, err_seen = 0, err_exp = 0;
  bit         bitq[$];
  logic [7:0] expq[$];
  bit         rand_ready = 1'b0, ready_force = 1'b1;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pb = '0;
`ifdef COEFF_TOKEN_CHROMA_DC_EN
  localparam bit CDC_EN = 1'b1;
`else
  localparam bit CDC_EN = 1'b0;
`endif
  string cw [17][4] = '{
    '{"1", "", "", ""},
    '{"000101", "01", "", ""},
    '{"00000111", "000100", "001", ""},
    '{"000000111", "00000110", "0000101", "00011"},
    '{"0000000111", "000000110", "00000101", "000011"},
    '{"00000000111", "0000000110", "000000101", "0000100"},
    '{"0000000001111", "00000000110", "0000000101", "00000100"},
    '{"0000000001011", "0000000001110", "00000000101", "000000100"},
    '{"0000000001000", "0000000001010", "0000000001101", "0000000100"},
    '{"00000000001111", "00000000001110", "0000000001001", "00000000100"},
    '{"00000000001011", "00000000001010", "00000000001101", "0000000001100"},
    '{"000000000001111", "000000000001110", "00000000001001", "00000000001100"},
    '{"000000000001011", "000000000001010", "000000000001101", "00000000001000"},
    '{"0000000000001111", "000000000000001", "000000000001001", "000000000001100"},
    '{"0000000000001011", "0000000000001110", "0000000000001101", "000000000001000"},
    '{"0000000000000111", "0000000000001010", "0000000000001001", "0000000000001100"},
    '{"0000000000000100", "0000000000000110", "0000000000000101", "0000000000001000"}};
  string ccw [5][4] = '{
    '{"01", "", "", ""},
    '{"000111", "1", "", ""},
    '{"000100", "000110", "001", ""},
    '{"000011", "0000011", "0000010", "000101"},
    '{"000010", "00000011", "00000010", "0000000"}};

  always #5 Clk = ~Clk;

  coeff_token_enc_packer dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .ChromaDC(ChromaDC),
    .FlushReq(FlushReq), .FlushDone(FlushDone), .OutValid(OutValid),
    .OutReady(OutReady), .OutByte(OutByte), .Err(Err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // empty string marks an illegal symbol
  function automatic string codeword(int tc, int t1, bit cdc);
    if (cdc && CDC_EN) return (tc <= 4 && t1 <= tc) ? ccw[tc][t1] : "";
    return (tc <= 16 && t1 <= tc) ? cw[tc][t1] : "";
  endfunction

  task automatic emit_bytes();
    logic [7:0] b;
    while (bitq.size() >= 8) begin
      for (int k = 0; k < 8; k++) b[7-k] = bitq.pop_front();
      expq.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int tc, input int t1);
    string s;
    int w;
    s = codeword(tc, t1, ChromaDC);
    w = 0;
    InValid = 1'b1;
    TotalCoeff = 5'(tc);
    TrailingOnes = 2'(t1);
    @(negedge Clk);
    while (!InReady && w < 300) begin
      @(negedge Clk);
      w++;
    end
    if (!InReady) chk("in_ready_timeout", 32'(InReady), 1);
    else if (s == "") err_exp++;
    else begin
      for (int i = 0; i < s.len(); i++) bitq.push_back(s[i] == "1");
      emit_bytes();
    end
    tick();
    InValid = 1'b0;
  endtask

  task automatic flush(input int exp_lat);
    int k;
    while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
    emit_bytes();
    FlushReq = 1'b1;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!FlushDone && k < 1000);
    chk("flush_done", 32'(FlushDone), 1);
    if (exp_lat > 0) chk("flush_latency", k, exp_lat);
    chk("drain_empty", expq.size(), 0);
    chk("err_count", err_seen, err_exp);
    tick();
    FlushReq = 1'b0;
    chk("flush_done_pulse", 32'(FlushDone), 0);
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  always @(negedge Clk) begin
    if (Err) err_seen++;
    if (pv && !pr && !Rst) begin
      chk("hold_valid", 32'(OutValid), 1);
      chk("hold_byte", 32'(OutByte), 32'(pb));
    end
    if (OutValid && OutReady) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_byte: got %0h expected no byte", OutByte);
      end else chk("out_byte", 32'(OutByte), 32'(expq.pop_front()));
    end
    pv <= OutValid;
    pr <= OutReady;
    pb <= OutByte;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, k, r;
    @(negedge Clk);
    chk("rst_in_ready", 32'(InReady), 0);
    chk("rst_out_valid", 32'(OutValid), 0);
    chk("rst_out_byte", 32'(OutByte), 0);
    chk("rst_flush_done", 32'(FlushDone), 0);
    chk("rst_err", 32'(Err), 0);
    tick();
    Rst = 1'b0;
    tick();
    // 1 01 001 00011 -> A4 60
    send(0, 0); send(1, 1); send(2, 2); send(3, 3);
    flush(-1);
    repeat (8) send(0, 0);
    repeat (5) tick();
    // empty accumulator: FlushDone on the third negedge, two cycles after the request cycle
    flush(3);
    send(3, 0); send(1, 0);
    flush(-1);
    send(4, 3); send(1, 2); send(5, 1);
    flush(-1);
    ready_force = 1'b0;
    tick();
    repeat (3) send(2, 0);
    @(negedge Clk);
    chk("in_ready_full", 32'(InReady), 0);
    repeat (4) tick();
    ready_force = 1'b1;
    repeat (2) send(2, 0);
    flush(-1);
    FlushReq = 1'b1;
    cnt = 0;
    k = 0;
    while (cnt < 2 && k < 20) begin
      @(negedge Clk);
      k++;
      if (FlushDone) cnt++;
    end
    chk("repeat_flush", cnt, 2);
    tick();
    FlushReq = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) flush(-1);
      else if (r < 3) tick();
      else send($urandom_range(0, 18), $urandom_range(0, 3));
    end
    flush(-1);
    rand_ready = 1'b0;
    ready_force = 1'b0;
    tick();
    repeat (10) send(0, 0);
    FlushReq = 1'b1;
    repeat (3) tick();
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(OutValid), 0);
    chk("async_rst_out_byte", 32'(OutByte), 0);
    chk("async_rst_in_ready", 32'(InReady), 0);
    chk("async_rst_flush_done", 32'(FlushDone), 0);
    bitq.delete();
    expq.delete();
    FlushReq = 1'b0;
    ready_force = 1'b1;
    repeat (2) tick();
    Rst = 1'b0;
    tick();
    send(0, 0);
    flush(-1);
`ifdef COEFF_TOKEN_CHROMA_DC_EN
    ChromaDC = 1'b1;
    send(1, 1); send(0, 0);
    flush(-1);
    send(5, 0);
    flush(-1);
    ChromaDC = 1'b0;
`endif
    chk("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/coeff_token_enc_packer.md
Name: coeff_token_enc_packer

Overview:
- CAVLC coeff_token encoder plus bit packer. It is the transmit-side counterpart of the coeff_token decode LUTs.
- Accepts (TotalCoeff, TrailingOnes) symbols and looks up the H.264 Table 9-5 codeword for 0<=nC<2.
- Appends each codeword MSB-first to a bit accumulator and emits packed bytes downstream over a valid/ready handshake.
- Sits between the residual-block symbol generator and the slice bitstream writer.

Parameters:
- ACC_W, 32, accumulator width in bits. Must be >= 24 (16-bit worst-case codeword + 8 residual bits).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- InValid  in  1  symbol valid.
- InReady  out  1  symbol accepted when InValid&&InReady.
- TotalCoeff  in  5  0..16.
- TrailingOnes  in  2  0..3.
- ChromaDC  in  1  selects the ChromaDC table (nC=-1); used only with the macro.
- FlushReq  in  1  level; requests byte alignment and drain.
- FlushDone  out  1  one-cycle pulse when the flush has completed.
- OutValid  out  1  OutByte valid.
- OutReady  in  1  downstream accepts the byte.
- OutByte  out  8  packed byte; first-coded bit in bit 7.
- Err  out  1  one-cycle pulse when an illegal symbol is dropped.

Behaviour:
- Reset (async, Rst high): Acc=0, Fill=0, state=RUN, InReady=0 for the reset cycle (then per rule), OutValid=0, OutByte=0, FlushDone=0, Err=0.
- States:
  - RUN: normal operation. Entered from reset.
  - FLUSH: RUN->FLUSH when FlushReq=1 and no symbol is accepted that cycle. An accepted symbol has priority; the flush is taken the next eligible cycle.
  - DONE: FLUSH->DONE when Fill==0. DONE asserts FlushDone for 1 cycle, then ->RUN.
- InReady = (state==RUN) && (Fill <= ACC_W-16), registered from current Fill.
- Symbol legality: TrailingOnes <= min(TotalCoeff,3) and TotalCoeff <= 16.
  - Illegal accepted symbol: consumed, no bits appended, Err pulses the next cycle.
- Lookup produces Code[15:0] (right-aligned) and Len[4:0], range 1..16. Both are combinational from inputs.
- Append: Acc gains Code in the next Len positions below the existing Fill bits; Fill += Len.
- Byte output: OutByte = Acc[ACC_W-1 -: 8] and OutValid = (Fill>=8), both registered.
  - On an OutValid&&OutReady handshake, Acc shifts left 8 and Fill -= 8.
  - Byte pop and symbol append in the same cycle are both applied: Fill_next = Fill - 8*pop + Len*push. Position the new bits against the post-pop Fill.
- Latency: a symbol accepted in cycle N whose bits complete a byte gives OutValid=1 in cycle N+1.
- FLUSH: if 0<Fill<8 (mod 8 residue), Fill rounds up to the next multiple of 8 with zero padding, then drain continues normally.
  - FlushReq with Fill==0: FLUSH->DONE immediately, FlushDone 2 cycles after the request.
- Backpressure: OutByte/OutValid hold stable while OutReady=0. No bit is ever lost or duplicated.
- FlushReq held high after DONE starts another flush. This is a no-op apart from another FlushDone pulse.

Optional Feature:
- Macro: COEFF_TOKEN_CHROMA_DC_EN.
- Defined: ChromaDC=1 selects the nC=-1 table, which has TotalCoeff 0..4. TotalCoeff>4 with ChromaDC=1 is illegal and raises Err.
- Undefined: ChromaDC is ignored and the 0<=nC<2 table is always used. Neither the table nor its logic is synthesized.

Decomposition:
- Package coeff_token_pkg holds:
  - ACC_W default
  - CODE_W=16
  - LEN_W=5
  - the state encoding RUN/FLUSH/DONE
- One sub-module: coeff_token_enc_lut. It is purely combinational: (TotalCoeff, TrailingOnes, ChromaDC) -> Code, Len, Illegal.
- The packer and state machine live in the top module.

Test Plan:
- Symbols (0,0),(1,1),(2,2),(3,3) then FlushReq -> bits 1,01,001,00011. OutByte 0xA4, then 0x60, then FlushDone pulse.
- Eight (0,0) symbols back-to-back, OutReady=1 -> single byte 0xFF. No further byte until flush. Flush with Fill==0 -> FlushDone only.
- (3,0) code 000000111 (len 9), then (1,0) code 000101 (len 6), then flush -> 0x03, 0x8A.
- Illegal (1,2) mid-stream -> Err pulse, no bits appended. Surrounding bytes are unchanged versus the same stream without it.
- OutReady=0 while streaming (2,0) codes (len 8) -> InReady drops once Fill>16, and OutByte holds stable. Releasing OutReady drains bytes 0x07 in order.
- Reset asserted mid-FLUSH -> all outputs 0 and Fill=0 asynchronously. After release, (0,0) plus flush yields 0x80.
- With COEFF_TOKEN_CHROMA_DC_EN defined: ChromaDC=1, symbols (1,1),(0,0) plus flush -> bits 1,01 -> 0xA0. Symbol (5,0) -> Err.
